// File: rtl/cluster_flit_port_if.sv
// Bundle of the router-side and core-side flit buses of a cluster node port.
// The slave view belongs to the port itself; the master view is the surrounding cores/router.
interface cluster_flit_port_if #(
  parameter int NODE_COUNT      = 16,
  parameter int PACKET_ID_WIDTH = 5,
  parameter int CORE_COUNT      = 4
);
  localparam int NB     = $clog2(NODE_COUNT);
  localparam int FLIT_W = 1 + 2*NB + 16 + 3 + PACKET_ID_WIDTH + 2;

  logic [CORE_COUNT*FLIT_W-1:0] core_flit_i;
  logic [CORE_COUNT-1:0]        core_ready_o;
  logic [FLIT_W-1:0]            net_flit_o;
  logic                         net_ready_i;
  logic [FLIT_W-1:0]            net_flit_i;
  logic                         net_ready_o;
  logic [CORE_COUNT*FLIT_W-1:0] core_flit_o;
  logic [CORE_COUNT-1:0]        core_ready_i;
  logic [7:0]                   drop_count_o;

  modport slave (
    input  core_flit_i, net_ready_i, net_flit_i, core_ready_i,
    output core_ready_o, net_flit_o, net_ready_o, core_flit_o, drop_count_o
  );

  modport master (
    output core_flit_i, net_ready_i, net_flit_i, core_ready_i,
    input  core_ready_o, net_flit_o, net_ready_o, core_flit_o, drop_count_o
  );
endinterface

// File: rtl/cluster_flit_port.sv
// Shared router port for a multi-core cluster node: packet-atomic round-robin egress
// arbitration onto one network output, and per-core receive FIFOs on ingress.
module cluster_flit_port #(
  parameter int NODE_COUNT      = 16,
  parameter int PACKET_ID_WIDTH = 5,
  parameter int CORE_COUNT      = 4,
  parameter int RX_FIFO_DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  cluster_flit_port_if.slave io_bus
);
  localparam int NB      = $clog2(NODE_COUNT);
  localparam int CB      = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;
  localparam int FLIT_W  = 1 + 2*NB + 16 + 3 + PACKET_ID_WIDTH + 2;
  localparam int VLD     = FLIT_W - 1;
  localparam int PID_LSB = 2;
  localparam int PW      = (RX_FIFO_DEPTH > 1) ? $clog2(RX_FIFO_DEPTH) : 1;
  localparam int CW      = $clog2(RX_FIFO_DEPTH + 1);

  localparam logic [CB-1:0] LAST_CORE = CB'(CORE_COUNT - 1);
  localparam logic [PW-1:0] LAST_SLOT = PW'(RX_FIFO_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(RX_FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [CB-1:0] core_inc(input logic [CB-1:0] v);
    return (v == LAST_CORE) ? '0 : v + CB'(1);
  endfunction

  function automatic logic [PW-1:0] slot_inc(input logic [PW-1:0] v);
    return (v == LAST_SLOT) ? '0 : v + PW'(1);
  endfunction

  // Egress arbitration and output register
  state_t                r_state, w_state_nxt;
  logic [CB-1:0]         r_grant, w_grant_nxt;
  logic [CB-1:0]         r_rr_ptr, w_rr_ptr_nxt;
  logic [CB-1:0]         w_pick;
  logic [FLIT_W-1:0]     r_net_flit;
  logic [FLIT_W-1:0]     w_grant_flit;
  logic [CORE_COUNT-1:0] w_core_vld;
  logic [CORE_COUNT-1:0] w_core_ready;
  logic                  w_out_free;
  logic                  w_xfer;
  logic                  w_tail;
  int                    w_best;
  int                    w_dist;

  always_comb begin
    w_core_vld   = '0;
    w_grant_flit = '0;
    for (int i = 0; i < CORE_COUNT; i++) begin
      w_core_vld[i] = io_bus.core_flit_i[i*FLIT_W + VLD];
      if (r_grant == CB'(i)) w_grant_flit = io_bus.core_flit_i[i*FLIT_W +: FLIT_W];
    end
  end

  // Round-robin pick: smallest distance from rr_ptr among valid cores.
  always_comb begin
    w_pick = r_rr_ptr;
    w_best = CORE_COUNT;
    w_dist = 0;
    for (int i = 0; i < CORE_COUNT; i++) begin
      if (w_core_vld[i]) begin
        w_dist = (i + CORE_COUNT - int'(r_rr_ptr)) % CORE_COUNT;
        if (w_dist < w_best) begin
          w_best = w_dist;
          w_pick = CB'(i);
        end
      end
    end
  end

  assign w_out_free = !r_net_flit[VLD] || io_bus.net_ready_i;
  assign w_xfer     = (r_state == S_LOCKED) && w_grant_flit[VLD] && w_out_free;
  assign w_tail     = (w_grant_flit[1:0] == 2'd3);

  always_comb begin
    w_core_ready = '0;
    for (int i = 0; i < CORE_COUNT; i++) begin
      w_core_ready[i] = (r_state == S_LOCKED) && (r_grant == CB'(i)) && w_out_free;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_rr_ptr_nxt = r_rr_ptr;
    case (r_state)
      S_IDLE: begin
        if (|w_core_vld) begin
          w_state_nxt = S_LOCKED;
          w_grant_nxt = w_pick;
        end
      end
      S_LOCKED: begin
        if (w_xfer && w_tail) begin
          w_state_nxt  = S_IDLE;
          w_rr_ptr_nxt = core_inc(r_grant);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_net_flit <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      if (w_xfer)                  r_net_flit <= w_grant_flit;
      else if (io_bus.net_ready_i) r_net_flit <= '0;
    end
  end

  // Ingress steering into per-core receive FIFOs
  logic [FLIT_W-1:0]            r_mem [CORE_COUNT][RX_FIFO_DEPTH];
  logic [PW-1:0]                r_wptr [CORE_COUNT];
  logic [PW-1:0]                r_rptr [CORE_COUNT];
  logic [CW-1:0]                r_count [CORE_COUNT];
  logic [7:0]                   r_drop_cnt;
  logic [CORE_COUNT-1:0]        w_full;
  logic [CORE_COUNT-1:0]        w_push;
  logic [CORE_COUNT-1:0]        w_pop;
  logic [CB-1:0]                w_rx_idx;
  logic                         w_net_ready;
  logic                         w_accept;
  logic                         w_drop;
  logic [CORE_COUNT*FLIT_W-1:0] w_core_flit;

  assign w_rx_idx    = io_bus.net_flit_i[PID_LSB +: CB];
  assign w_net_ready = !rst && !(|w_full);
  assign w_accept    = io_bus.net_flit_i[VLD] && w_net_ready;
  assign w_drop      = w_accept && !(|w_push);

  // Readiness looks only at current occupancy, so a full FIFO blocks even while it pops.
  always_comb begin
    w_full = '0;
    w_push = '0;
    w_pop  = '0;
    for (int i = 0; i < CORE_COUNT; i++) begin
      w_full[i] = (r_count[i] == FULL_CNT);
      w_push[i] = w_accept && (w_rx_idx == CB'(i));
      w_pop[i]  = (r_count[i] != '0) && io_bus.core_ready_i[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
      for (int i = 0; i < CORE_COUNT; i++) begin
        r_wptr[i]  <= '0;
        r_rptr[i]  <= '0;
        r_count[i] <= '0;
      end
    end else begin
      if (w_drop) r_drop_cnt <= sat_inc8(r_drop_cnt);
      for (int i = 0; i < CORE_COUNT; i++) begin
        if (w_push[i]) r_wptr[i] <= slot_inc(r_wptr[i]);
        if (w_pop[i])  r_rptr[i] <= slot_inc(r_rptr[i]);
        if (w_push[i] && !w_pop[i])      r_count[i] <= r_count[i] + CW'(1);
        else if (!w_push[i] && w_pop[i]) r_count[i] <= r_count[i] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < CORE_COUNT; i++) begin
      if (w_push[i]) r_mem[i][r_wptr[i]] <= io_bus.net_flit_i;
    end
  end

  always_comb begin
    w_core_flit = '0;
    for (int i = 0; i < CORE_COUNT; i++) begin
      if (r_count[i] != '0) w_core_flit[i*FLIT_W +: FLIT_W] = r_mem[i][r_rptr[i]];
    end
  end

  assign io_bus.core_ready_o = w_core_ready;
  assign io_bus.net_flit_o   = r_net_flit;
  assign io_bus.net_ready_o  = w_net_ready;
  assign io_bus.core_flit_o  = w_core_flit;
  assign io_bus.drop_count_o = r_drop_cnt;
endmodule
